// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants: framing bytes, CRC-32 parameters and
// the receive FSM state encoding.
package eth_pkg;

  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wise reflected CRC-32 next-state logic (purely combinational).
// Only present when XMII_RX_CRC_EN is defined, so a default build carries
// no CRC logic at all.
`ifdef XMII_RX_CRC_EN
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  // Bit-serial reflected update unrolled over one byte, LSB first
  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[0] ^ data[i])
        crc_next = (crc_next >> 1) ^ CRC32_POLY;
      else
        crc_next = crc_next >> 1;
    end
  end

endmodule
`endif

// File: rtl/xmii_rx.sv
// RMII/MII receive deframer: hunts the SFD, assembles bytes from DW-bit
// line symbols and streams them out with frame length and error status.
// Optional build macro: XMII_RX_CRC_EN adds FCS checking via eth_crc32.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | line quiet, waiting for crs_dv
// ST_PREAMBLE | shifting preamble symbols, looking for the SFD
// ST_DATA     | assembling bytes, one byte held back to mark the last one
// ST_DROP     | frame overran MAX_BYTES, discarding until crs_dv drops
module xmii_rx
  import eth_pkg::*;
#(
  parameter int DW        = 2,
  parameter int MAX_BYTES = 1522,
  parameter int MIN_BYTES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          crs_dv,
  input  logic [DW-1:0] rx_d,
  input  logic          rx_er,
  output logic [7:0]    m_data,
  output logic          m_valid,
  output logic          m_last,
  output logic          m_err,
  output logic [15:0]   m_len
);

  localparam int         SYMS     = 8 / DW;
  localparam logic [1:0] SYM_LAST = 2'(SYMS - 1);

  rx_state_e     state;
  // Only the upper 8-DW bits of each shift window are stored; the newest
  // symbol is concatenated on top combinationally to form the full byte.
  logic [7-DW:0] pre_sr;
  logic [7-DW:0] acc;
  logic [1:0]    sym_cnt;
  logic [7:0]    hold_data;
  logic          hold_vld;
  logic          er_seen;
  logic [15:0]   len_cnt;

  logic [7:0]    pre_next;
  logic [7:0]    byte_next;
  logic [15:0]   len_inc;
  logic          partial;
  logic          too_short;
  logic          crc_bad;

  assign pre_next  = {rx_d, pre_sr};
  assign byte_next = {rx_d, acc};
  assign len_inc   = (len_cnt >= 16'(MAX_BYTES)) ? 16'(MAX_BYTES) : len_cnt + 16'd1;
  assign partial   = (sym_cnt != SYM_LAST);
  assign too_short = (len_inc < 16'(MIN_BYTES));
  assign m_len     = len_cnt;

`ifdef XMII_RX_CRC_EN
  logic [31:0] crc;
  logic [31:0] crc_next;

  eth_crc32 u_crc (
    .crc      (crc),
    .data     (byte_next),
    .crc_next (crc_next)
  );

  // Running CRC over every completed DATA byte, FCS included
  always_ff @(posedge clk) begin
    if (rst)
      crc <= CRC32_INIT;
    else if (state == ST_PREAMBLE)
      crc <= CRC32_INIT;
    else if (state == ST_DATA && crs_dv && sym_cnt == 2'd0)
      crc <= crc_next;
  end

  assign crc_bad = (crc != CRC32_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // Receive FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pre_sr    <= '0;
      acc       <= '0;
      sym_cnt   <= SYM_LAST;
      hold_data <= '0;
      hold_vld  <= 1'b0;
      er_seen   <= 1'b0;
      len_cnt   <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_err     <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (crs_dv) begin
            pre_sr <= pre_next[7:DW];
            state  <= ST_PREAMBLE;
          end else begin
            pre_sr <= '0;
          end
        end

        ST_PREAMBLE: begin
          if (!crs_dv) begin
            pre_sr <= '0;
            state  <= ST_IDLE;
          end else if (pre_next == ETH_SFD) begin
            pre_sr   <= '0;
            sym_cnt  <= SYM_LAST;
            hold_vld <= 1'b0;
            er_seen  <= 1'b0;
            len_cnt  <= '0;
            state    <= ST_DATA;
          end else begin
            pre_sr <= pre_next[7:DW];
          end
        end

        ST_DATA: begin
          if (!crs_dv) begin
            // Frame end: flush the held byte as the last one, if any byte ever completed
            if (hold_vld) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_data  <= hold_data;
              m_err   <= er_seen | partial | too_short | crc_bad;
              len_cnt <= len_inc;
            end
            hold_vld <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            if (rx_er)
              er_seen <= 1'b1;
            acc <= byte_next[7:DW];
            if (sym_cnt == 2'd0) begin
              sym_cnt   <= SYM_LAST;
              hold_data <= byte_next;
              hold_vld  <= 1'b1;
              if (hold_vld) begin
                m_valid <= 1'b1;
                m_data  <= hold_data;
                len_cnt <= len_inc;
                // A byte beyond MAX_BYTES just completed: close the frame as bad
                if (len_cnt == 16'(MAX_BYTES - 1)) begin
                  m_last   <= 1'b1;
                  m_err    <= 1'b1;
                  hold_vld <= 1'b0;
                  state    <= ST_DROP;
                end
              end
            end else begin
              sym_cnt <= sym_cnt - 2'd1;
            end
          end
        end

        ST_DROP: begin
          if (!crs_dv)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xmii_rx.sv
// Self-checking bench for xmii_rx: three instances (RMII, MII, RMII with a
// small MAX_BYTES) driven one at a time; expected bytes are queued when a
// frame is driven and compared as the DUT strobes them out.
module tb_xmii_rx;
  import eth_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  crs_dv;
  logic [2:0]  rx_er;
  logic [3:0]  rx_d [3];
  logic [7:0]  m_data [3];
  logic [2:0]  m_valid;
  logic [2:0]  m_last;
  logic [2:0]  m_err;
  logic [15:0] m_len [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [25:0] q0[$];
  logic [25:0] q1[$];
  logic [25:0] q2[$];
  logic [7:0]  fb [0:255];
  bit   [2:0]  prev_ok = '0;
  int          prev_cyc [3];

  xmii_rx #(.DW(2)) u0 (
    .clk(clk), .rst(rst), .crs_dv(crs_dv[0]), .rx_d(rx_d[0][1:0]), .rx_er(rx_er[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]), .m_err(m_err[0]), .m_len(m_len[0])
  );

  xmii_rx #(.DW(4)) u1 (
    .clk(clk), .rst(rst), .crs_dv(crs_dv[1]), .rx_d(rx_d[1]), .rx_er(rx_er[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]), .m_err(m_err[1]), .m_len(m_len[1])
  );

  xmii_rx #(.DW(2), .MAX_BYTES(100)) u2 (
    .clk(clk), .rst(rst), .crs_dv(crs_dv[2]), .rx_d(rx_d[2][1:0]), .rx_er(rx_er[2]),
    .m_data(m_data[2]), .m_valid(m_valid[2]), .m_last(m_last[2]), .m_err(m_err[2]), .m_len(m_len[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: run exceeded its time budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dw_of(input int i);
    return (i == 1) ? 4 : 2;
  endfunction

  function automatic int max_of(input int i);
    return (i == 2) ? 100 : 1522;
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [25:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [25:0] v);
    case (i)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      r = (r[0] ^ b[k]) ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    return r;
  endfunction

  // FCS check expressed as "complemented CRC of payload equals trailing 4 bytes"
  function automatic logic fcs_bad(input int n);
`ifdef XMII_RX_CRC_EN
    logic [31:0] c;
    c = CRC32_INIT;
    if (n < 4) return 1'b1;
    for (int k = 0; k < n - 4; k++) c = crc_byte(c, fb[k]);
    c = ~c;
    return c != {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
`else
    return (n < 0);
`endif
  endfunction

  task automatic expect_frame(input int i, input int n, input int extra, input int er_byte);
    int   mx;
    logic err;
    mx = max_of(i);
    if (n > mx) begin
      for (int k = 0; k < mx; k++)
        push_exp(i, {fb[k], (k == mx - 1), 1'b1, 16'(mx)});
    end else begin
      err = (er_byte >= 0 && er_byte < n) || (extra != 0) || (n < 64) || fcs_bad(n);
      for (int k = 0; k < n; k++)
        push_exp(i, {fb[k], (k == n - 1), err, 16'(n)});
    end
  endtask

  task automatic drive_sym(input int i, input logic dv, input logic [3:0] d, input logic er);
    @(posedge clk);
    #1;
    crs_dv[i] = dv;
    rx_d[i]   = d;
    rx_er[i]  = er;
  endtask

  task automatic send_byte(input int i, input logic [7:0] b, input logic er);
    int dw;
    logic [7:0] v;
    dw = dw_of(i);
    v  = b;
    for (int s = 0; s < 8 / dw; s++) begin
      drive_sym(i, 1'b1, (dw == 4) ? v[3:0] : {2'b00, v[1:0]}, er);
      v = v >> dw;
    end
  endtask

  // abort_at >= 0 pulses rst after that many data bytes instead of ending normally
  task automatic send(input int i, input int n, input int extra, input int er_byte,
                      input int abort_at, input int tail);
    for (int b = 0; b < 8; b++) send_byte(i, (b < 7) ? ETH_PREAMBLE : ETH_SFD, 1'b0);
    for (int b = 0; b < n; b++) begin
      if (b == abort_at) begin
        @(posedge clk);
        #1;
        rst       = 1'b1;
        crs_dv[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (tail) @(posedge clk);
        return;
      end
      send_byte(i, fb[b], (b == er_byte));
    end
    for (int s = 0; s < extra; s++) drive_sym(i, 1'b1, 4'h2, 1'b0);
    drive_sym(i, 1'b0, 4'h0, 1'b0);
    repeat (tail) @(posedge clk);
  endtask

  task automatic drain(input int i, input string tag);
    for (int k = 0; k < 400 && qsize(i) != 0; k++) @(posedge clk);
    repeat (10) @(posedge clk);
    chk($sformatf("u%0d %s pending", i, tag), 32'(qsize(i)), 32'd0);
  endtask

  task automatic mon(input int i);
    logic [25:0] e;
    if (qsize(i) == 0) begin
      chk($sformatf("u%0d spurious_strobe", i), 32'(m_valid[i]), 32'd0);
      return;
    end
    pop_exp(i, e);
    chk($sformatf("u%0d data", i), 32'(m_data[i]), 32'(e[25:18]));
    chk($sformatf("u%0d last", i), 32'(m_last[i]), 32'(e[17]));
    if (e[17]) begin
      chk($sformatf("u%0d err", i), 32'(m_err[i]), 32'(e[16]));
      chk($sformatf("u%0d len", i), 32'(m_len[i]), 32'(e[15:0]));
    end
    if (!m_last[i] && prev_ok[i])
      chk($sformatf("u%0d strobe_gap", i), 32'(cyc - prev_cyc[i]), 32'(8 / dw_of(i)));
    prev_ok[i]  = !m_last[i];
    prev_cyc[i] = cyc;
  endtask

  // Scoreboard side: every strobe is matched against the queued expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (m_valid[i] === 1'b1) mon(i);
    if (rst) prev_ok = '0;
  end

  task automatic fill_ramp(input int n, input int base);
    for (int k = 0; k < n; k++) fb[k] = 8'(base + k);
  endtask

  initial begin
    logic [31:0] c;
    rst    = 1'b1;
    crs_dv = '0;
    rx_er  = '0;
    for (int i = 0; i < 3; i++) rx_d[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d rst m_data", i),  32'(m_data[i]),  32'd0);
      chk($sformatf("u%0d rst m_valid", i), 32'(m_valid[i]), 32'd0);
      chk($sformatf("u%0d rst m_last", i),  32'(m_last[i]),  32'd0);
      chk($sformatf("u%0d rst m_err", i),   32'(m_err[i]),   32'd0);
      chk($sformatf("u%0d rst m_len", i),   32'(m_len[i]),   32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic 64-byte ramp frames on RMII and MII
    fill_ramp(64, 0);
    expect_frame(0, 64, 0, -1); send(0, 64, 0, -1, -1, 4); drain(0, "rmii_ramp");
    expect_frame(1, 64, 0, -1); send(1, 64, 0, -1, -1, 4); drain(1, "mii_ramp");

    // PHY error mid-frame, trailing odd dibit, short frame
    expect_frame(0, 64, 0, 10); send(0, 64, 0, 10, -1, 4); drain(0, "rx_er");
    expect_frame(0, 64, 1, -1); send(0, 64, 1, -1, -1, 4); drain(0, "align");
    fill_ramp(20, 8'h90);
    expect_frame(0, 20, 0, -1); send(0, 20, 0, -1, -1, 4); drain(0, "short");

    // Oversize frame then a normal one on the small-MAX instance
    fill_ramp(200, 0);
    expect_frame(2, 200, 0, -1); send(2, 200, 0, -1, -1, 4); drain(2, "oversize");
    fill_ramp(64, 8'h40);
    expect_frame(2, 64, 0, -1); send(2, 64, 0, -1, -1, 4); drain(2, "after_drop");

    // 60-byte payload plus correct FCS, then the same with a flipped payload bit
    for (int k = 0; k < 60; k++) fb[k] = 8'(k * 7 + 3);
    c = CRC32_INIT;
    for (int k = 0; k < 60; k++) c = crc_byte(c, fb[k]);
    c = ~c;
    fb[60] = c[7:0]; fb[61] = c[15:8]; fb[62] = c[23:16]; fb[63] = c[31:24];
    expect_frame(0, 64, 0, -1); send(0, 64, 0, -1, -1, 4); drain(0, "fcs_good");
    fb[5] = fb[5] ^ 8'h10;
    expect_frame(0, 64, 0, -1); send(0, 64, 0, -1, -1, 4); drain(0, "fcs_bad");

    // Reset in mid-frame: bytes already strobed appear, no m_last, then a clean frame
    fill_ramp(64, 8'hA0);
    for (int k = 0; k < 19; k++) push_exp(0, {fb[k], 1'b0, 1'b0, 16'd0});
    send(0, 64, 0, -1, 20, 4); drain(0, "abort");
    expect_frame(0, 64, 0, -1); send(0, 64, 0, -1, -1, 4); drain(0, "post_abort");

    // Back-to-back frames with only the crs_dv-low cycle between them
    fill_ramp(64, 8'h10);
    expect_frame(1, 64, 0, -1); send(1, 64, 0, -1, -1, 0);
    fill_ramp(70, 8'hC0);
    expect_frame(1, 70, 0, -1); send(1, 70, 0, -1, -1, 4); drain(1, "b2b");

    // Frame that ends before any byte completes: no output at all
    send(0, 0, 2, -1, -1, 4); drain(0, "no_byte");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
